// File: rtl/game_pkg.sv
// Shared game-level encodings, probe FSM states and default shift periods
// used by the wall prober and its tick timer.
package game_pkg;

    localparam logic [2:0] LVL_EASY = 3'd1;
    localparam logic [2:0] LVL_MED  = 3'd2;
    localparam logic [2:0] LVL_HARD = 3'd3;

    localparam logic [2:0] SEXT_MIN = 3'd1;
    localparam logic [2:0] SEXT_MAX = 3'd6;

    localparam int PERIOD_EASY_DEF = 400000;
    localparam int PERIOD_MED_DEF  = 300000;
    localparam int PERIOD_HARD_DEF = 200000;
    localparam int TIMER_W         = 20;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_TICK,
        ST_GAP,
        ST_PROBE,
        ST_DRAIN,
        ST_HIT
    } probe_state_t;

    function automatic logic sext_ok(input logic [2:0] s);
        return (s >= SEXT_MIN) && (s <= SEXT_MAX);
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Level-dependent shift timer. Raises due once the count reaches the
// selected period; due stays up (count held) until the prober can accept it.
module tick_timer
    import game_pkg::*;
#(
    parameter int PERIOD_EASY = PERIOD_EASY_DEF,
    parameter int PERIOD_MED  = PERIOD_MED_DEF,
    parameter int PERIOD_HARD = PERIOD_HARD_DEF
) (
    input  logic       Clk,
    input  logic       Reset_l,
    input  logic       clr,
    input  logic       run,
    input  logic       ack,
    input  logic [2:0] level,
    output logic       due
);

    logic [TIMER_W-1:0] cnt;
    logic [TIMER_W-1:0] last;
    logic               lvl_ok;

    always_comb begin
        last = '0;
        case (level)
            LVL_EASY: last = TIMER_W'(PERIOD_EASY - 1);
            LVL_MED:  last = TIMER_W'(PERIOD_MED - 1);
            LVL_HARD: last = TIMER_W'(PERIOD_HARD - 1);
            default:  last = '0;
        endcase
    end

    assign lvl_ok = (level == LVL_EASY) || (level == LVL_MED) || (level == LVL_HARD);
    // >= rather than == so a drop to a shorter period fires on the next cycle
    assign due    = run && lvl_ok && (cnt >= last);

    always_ff @(posedge Clk or negedge Reset_l) begin
        if (!Reset_l) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (due) begin
            if (ack) cnt <= '0;
        end else if (run && lvl_ok) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wall_probe.sv
// Wall store query initiator: issues move_walls shift ticks and, after each
// shift, scans a radius window at the player's sextant for a collision.
module wall_probe
    import game_pkg::*;
#(
    parameter int PLAYER_RADIUS = 40,
    parameter int PROBE_DEPTH   = 8,
    parameter int PERIOD_EASY   = PERIOD_EASY_DEF,
    parameter int PERIOD_MED    = PERIOD_MED_DEF,
    parameter int PERIOD_HARD   = PERIOD_HARD_DEF,
    parameter int TICK_HIGH     = 2
) (
    input  logic       Clk,
    input  logic       Reset_l,
    input  logic       kb_reset,
    input  logic [2:0] State,
    input  logic [2:0] player_sextant,
    input  logic       is_wall,
    output logic [9:0] radius,
    output logic [2:0] sextant,
    output logic       probe_active,
    output logic       move_walls,
    output logic       collision,
    output logic       probe_done
);

    if (PLAYER_RADIUS + PROBE_DEPTH - 1 > 400) begin : g_bad_radius
        $error("wall_probe: probe window exceeds radius 400");
    end
    if (PROBE_DEPTH < 1 || PROBE_DEPTH > 64) begin : g_bad_depth
        $error("wall_probe: PROBE_DEPTH out of range 1..64");
    end
    if (TICK_HIGH < 1 || TICK_HIGH > 256) begin : g_bad_tick
        $error("wall_probe: TICK_HIGH out of range 1..256");
    end

    localparam logic [9:0] RAD0     = 10'(PLAYER_RADIUS);
    localparam logic [5:0] IDX_LAST = 6'(PROBE_DEPTH - 1);
    localparam logic [7:0] TH_LAST  = 8'(TICK_HIGH - 1);

    probe_state_t st;
    logic [5:0]   idx;
    logic [7:0]   th_cnt;
    logic         samp_q;
    logic         samp_vld;
    logic         due;
    logic         hit;

    tick_timer #(
        .PERIOD_EASY(PERIOD_EASY),
        .PERIOD_MED (PERIOD_MED),
        .PERIOD_HARD(PERIOD_HARD)
    ) u_timer (
        .Clk    (Clk),
        .Reset_l(Reset_l),
        .clr    (kb_reset),
        .run    (st != ST_HIT),
        .ack    (st == ST_WAIT),
        .level  (State),
        .due    (due)
    );

    // samp_q holds is_wall for the address presented one cycle earlier
    assign hit = samp_vld && samp_q;

    always_ff @(posedge Clk or negedge Reset_l) begin
        if (!Reset_l) begin
            st           <= ST_WAIT;
            idx          <= '0;
            th_cnt       <= '0;
            samp_q       <= 1'b0;
            samp_vld     <= 1'b0;
            radius       <= '0;
            sextant      <= '0;
            probe_active <= 1'b0;
            move_walls   <= 1'b0;
            collision    <= 1'b0;
            probe_done   <= 1'b0;
        end else if (kb_reset) begin
            st           <= ST_WAIT;
            idx          <= '0;
            th_cnt       <= '0;
            samp_q       <= 1'b0;
            samp_vld     <= 1'b0;
            radius       <= '0;
            sextant      <= '0;
            probe_active <= 1'b0;
            move_walls   <= 1'b0;
            collision    <= 1'b0;
            probe_done   <= 1'b0;
        end else begin
            probe_done <= 1'b0;
            samp_q     <= is_wall;
            samp_vld   <= probe_active;
            case (st)
                ST_WAIT: begin
                    if (due) begin
                        st         <= ST_TICK;
                        move_walls <= 1'b1;
                        th_cnt     <= '0;
                    end
                end
                ST_TICK: begin
                    if (th_cnt == TH_LAST) begin
                        st         <= ST_GAP;
                        move_walls <= 1'b0;
                    end else begin
                        th_cnt <= th_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (sext_ok(player_sextant)) begin
                        st           <= ST_PROBE;
                        idx          <= '0;
                        probe_active <= 1'b1;
                        radius       <= RAD0;
                        sextant      <= player_sextant;
                    end else begin
                        st         <= ST_WAIT;
                        probe_done <= 1'b1;
                    end
                end
                ST_PROBE, ST_DRAIN: begin
                    if (hit) begin
                        st           <= ST_HIT;
                        collision    <= 1'b1;
                        probe_active <= 1'b0;
                        radius       <= '0;
                        sextant      <= '0;
                    end else if (st == ST_DRAIN) begin
                        st           <= ST_WAIT;
                        probe_active <= 1'b0;
                        radius       <= '0;
                        sextant      <= '0;
                        probe_done   <= 1'b1;
                    end else if (idx == IDX_LAST) begin
                        st <= ST_DRAIN;
                    end else begin
                        idx    <= idx + 1'b1;
                        radius <= RAD0 + {4'd0, idx} + 10'd1;
                    end
                end
                ST_HIT: begin
                end
                default: st <= ST_WAIT;
            endcase
        end
    end

endmodule

// File: doc/wall_probe.md
Name: wall_probe

Overview:
- Initiator/reader side of the wall store's query interface.
- Generates the move_walls shift tick at a level-dependent rate.
- After each shift, walks a radius window at the player's sextant, samples is_wall and raises a sticky collision flag.
- Sits between the game state controller and the wall store; the renderer's radius/sextant mux selects this block while probe_active=1.

Parameters:
- PLAYER_RADIUS, 40, first radius probed (player ring inner edge).
- PROBE_DEPTH, 8, number of consecutive radii probed per shift (1..64).
- PERIOD_EASY, 400000, Clk cycles between shifts when State=1.
- PERIOD_MED, 300000, Clk cycles between shifts when State=2.
- PERIOD_HARD, 200000, Clk cycles between shifts when State=3.
- TICK_HIGH, 2, cycles move_walls is held high per shift (at least 1).

Ports:
- Clk  in  1  system clock
- Reset_l  in  1  asynchronous active-low reset
- kb_reset  in  1  synchronous game restart, level-sensitive
- State  in  3  game level: 1 easy, 2 medium, 3 hard; any other value pauses
- player_sextant  in  3  player sextant, valid range 1..6
- is_wall  in  1  wall store response for the current radius/sextant (combinational in store)
- radius  out  10  probe radius; 0 when idle
- sextant  out  3  probe sextant; 0 when idle
- probe_active  out  1  this block owns the query port
- move_walls  out  1  shift tick to wall store
- collision  out  1  sticky hit flag
- probe_done  out  1  one-cycle pulse at end of each probe window

Behaviour:
- Reset (Reset_l=0, async): FSM=WAIT; tick counter=0; all outputs 0.
- kb_reset=1 at a clock edge: same state as reset; takes priority over all other events.
- FSM states: WAIT, TICK, GAP, PROBE, DRAIN, HIT.
- WAIT:
  - Counter increments only when State is 1..3; otherwise counter and FSM hold (pause).
  - When counter = period(State)-1: counter clears, go to TICK.
  - A State change mid-count keeps the counter. If the counter is already at or above the new period-1, the tick fires on the next cycle.
- TICK: move_walls=1 for exactly TICK_HIGH cycles, then GAP.
- GAP: one cycle with move_walls=0, so the store's edge completes before reads.
  - Latch player_sextant into sext_q.
  - If sext_q is 0 or 7: skip probing, pulse probe_done, return to WAIT.
  - Otherwise go to PROBE with idx=0.
- PROBE:
  - probe_active=1, radius=PLAYER_RADIUS+idx, sextant=sext_q.
  - is_wall is registered the cycle after each address is presented, so sample k corresponds to idx=k-1.
  - idx increments each cycle up to PROBE_DEPTH-1, then DRAIN.
- DRAIN: one cycle with probe_active=1 and the last address held; collects the final sample.
- Hit detection:
  - Any registered sample = 1 sets collision=1 on the following edge; FSM goes to HIT and probe_active drops immediately.
  - If no hit: pulse probe_done on DRAIN exit, return to WAIT.
- HIT: terminal. move_walls stays 0, probe_active=0, collision held at 1. Exit only via kb_reset or Reset_l.
- player_sextant changes during PROBE are ignored (sext_q is latched).
- Width rules:
  - PLAYER_RADIUS+PROBE_DEPTH-1 must be at most 400; elaboration assertion.
  - Tick counter is 20 bits, unsigned; period(State) is selected combinationally.
- Tick-to-tick spacing equals the period exactly; probe cycles overlap counting (the counter keeps running from the TICK entry).
  - Required: period > TICK_HIGH+PROBE_DEPTH+3; otherwise a tick due during PROBE is deferred to WAIT re-entry.

Decomposition:
- Shared package game_pkg:
  - level encodings LVL_EASY=1, LVL_MED=2, LVL_HARD=3.
  - sextant range constants SEXT_MIN=1, SEXT_MAX=6.
  - FSM state enum probe_state_t.
  - Default period constants.
- One sub-module, tick_timer: counter, period select, pause, and done pulse.
- Probe FSM and sample register stay in wall_probe.

Test Plan:
- Periods 20/15/10, TICK_HIGH=2, State=1, is_wall=0 → move_walls rises every 20 cycles, high 2 cycles; radius sweeps 40..47; probe_done pulses once per tick; collision stays 0.
- player_sextant=3, is_wall=1 only when radius=45 and sextant=3 → collision=1 two cycles after radius=45 is presented; probe_active=0 thereafter; no further move_walls pulses.
- State=0 held for 50 cycles mid-count at counter=7 → no ticks; after State=1, the tick fires 13 cycles later.
- player_sextant=7 at GAP → no probe_active, probe_done pulses, next tick still on schedule.
- In HIT, assert kb_reset for 1 cycle → collision=0, FSM=WAIT, counter=0; the first tick follows exactly one period later.
- Reset_l driven low asynchronously during PROBE (idx=3) → all outputs 0 immediately, without waiting for a clock edge; after release, behaviour is identical to power-up.
